// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width; never below one bit so WIDTH=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full-adder slice; the only arithmetic in the serial datapath.
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, valid/ready on both sides.
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             accept, step, last;
    logic             fa_s, fa_co;

    serial_fa_slice u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next state and handshake; in_ready depends only on state, out_ready and rst.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        last     = (cnt_q == CW'(WIDTH - 1));
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    accept  = in_valid;
                    state_d = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            in_ready = 1'b0;
            accept   = 1'b0;
            step     = 1'b0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Operand shifters, carry, counter and result; sum fills from the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            sa_q    <= a;
            sb_q    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            sa_q    <= sa_q >> 1;
            sb_q    <= sb_q >> 1;
            sum_q   <= (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry_q <= fa_co;
            cnt_q   <= cnt_q + CW'(1);
            if (last) cout_q <= fa_co;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit at WIDTH=8 and WIDTH=1.
module tb_serial_add_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [7:0] a, b, sum;

    logic       rst1, in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;

    serial_add_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_add_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE with out_ready held high; checks latency and result.
    task automatic run_one(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                           input logic [7:0] es, input logic ec);
        int lat;
        out_ready = 1'b1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        #1;
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(9));
        chk("sum", 64'(sum), 64'(es));
        chk("cout", 64'(cout), 64'(ec));
        tick();
        chk("idle_after", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    endtask

    // Random traffic at WIDTH=8 against a queue of a+b+cin results.
    task automatic rand8(input int n);
        logic [8:0] q[$];
        logic [8:0] e;
        int sent = 0, got = 0, cyc = 0;
        logic acc;
        in_valid = 1'b0;
        while (got < n && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < n && $urandom_range(0, 1) == 1) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r8_extra actual=%0h required=none", {cout, sum});
                end else begin
                    e = q.pop_front();
                    chk("r8_result", 64'({cout, sum}), 64'(e));
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
                sent++;
            end
            tick();
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        chk("r8_count", 64'(got), 64'(n));
        chk("r8_leftover", 64'(q.size()), 64'(0));
        out_ready = 1'b1;
    endtask

    // Random traffic at WIDTH=1; every operand combination shows up many times.
    task automatic rand1(input int n);
        logic [1:0] q[$];
        logic [1:0] e;
        int sent = 0, got = 0, cyc = 0;
        logic acc;
        in_valid1 = 1'b0;
        while (got < n && cyc < 40000) begin
            out_ready1 = ($urandom_range(0, 3) != 0);
            if (!in_valid1 && sent < n && $urandom_range(0, 1) == 1) begin
                a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); in_valid1 = 1'b1;
            end
            #1;
            if (out_valid1 && out_ready1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r1_extra actual=%0h required=none", {cout1, sum1});
                end else begin
                    e = q.pop_front();
                    chk("r1_result", 64'({cout1, sum1}), 64'(e));
                end
                got++;
            end
            acc = in_valid1 && in_ready1;
            if (acc) begin
                q.push_back(2'(a1) + 2'(b1) + 2'(cin1));
                sent++;
            end
            tick();
            cyc++;
            if (acc) in_valid1 = 1'b0;
        end
        chk("r1_count", 64'(got), 64'(n));
        chk("r1_leftover", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int lat;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
        tick();
        tick();
        chk("in_ready_in_reset", 64'(in_ready), 64'(0));
        chk("reset_state", 64'({out_valid, busy, cout, sum}), 64'(0));
        chk("reset_state_w1", 64'({out_valid1, busy1, cout1, sum1}), 64'(0));
        rst = 1'b0; rst1 = 1'b0;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'(1));

        for (int i = 0; i < 6; i++)
            run_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);

        // Stalled consumer: result must hold and no new operands accepted.
        out_ready = 1'b0;
        a = 8'hA5; b = 8'h5A; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("stall_latency", 64'(lat), 64'(9));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", 64'({out_valid, in_ready, cout, sum}), 64'({1'b1, 1'b0, 1'b1, 8'h00}));
        end
        out_ready = 1'b1;
        #1;
        chk("stall_in_ready_release", 64'(in_ready), 64'(1));
        tick();
        chk("stall_drain", 64'({out_valid, in_ready}), 64'(2'b01));

        // Back-to-back handoff in DONE.
        out_ready = 1'b0;
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'h80; b = 8'h80; cin = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("b2b_first", 64'({cout, sum}), 64'(9'h046));
        chk("b2b_in_ready_blocked", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready_follow", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        chk("b2b_running", 64'({out_valid, busy}), 64'(2'b01));
        lat = 1;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("b2b_latency", 64'(lat), 64'(9));
        chk("b2b_second", 64'({cout, sum}), 64'(9'h100));
        tick();

        // Reset during the fourth RUN cycle discards the partial result.
        a = 8'h7F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid_run_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_run_in_ready_rst", 64'(in_ready), 64'(0));
        tick();
        chk("mid_run_reset", 64'({out_valid, busy, cout, sum}), 64'(0));
        rst = 1'b0;
        #1;
        chk("mid_run_idle", 64'(in_ready), 64'(1));
        run_one(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        rand8(500);
        rand1(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
